// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line in, recovered byte plus status strobes out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_d;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_busy;

  modport slave  (input rx, output rx_d, rx_valid, rx_err, rx_busy);
  modport master (output rx, input rx_d, rx_valid, rx_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-cycle valid/error strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic     clk_125MHz,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMR_HALF = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] TMR_END  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rx_m, r_rx_s, r_rx_q;
  logic [TW-1:0] r_tmr;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift, r_rx_d;
  logic          r_valid, r_err;
  logic          w_fall, w_tmr_clr, w_sample, w_load, w_ferr;

  // Sync and history flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_q <= 1'b1;
    end else begin
      r_rx_m <= bus.rx;
      r_rx_s <= r_rx_m;
      r_rx_q <= r_rx_s;
    end
  end

  assign w_fall = r_rx_q & ~r_rx_s;

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    w_sample    = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmr_clr = 1'b1;
        if (w_fall) w_state_nxt = START;
      end
      START: begin
        if (r_tmr == TMR_HALF) begin
          w_tmr_clr   = 1'b1;
          w_state_nxt = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_tmr == TMR_END) begin
          w_sample  = 1'b1;
          w_tmr_clr = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_tmr == TMR_END) begin
          w_tmr_clr = 1'b1;
          if (r_rx_s) begin
            w_load      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Held-low (break) line parks here so it cannot retrigger frames.
        w_tmr_clr = 1'b1;
        if (r_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      r_tmr   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_rx_d  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_tmr   <= w_tmr_clr ? '0 : r_tmr + TW'(1);
      r_valid <= w_load;
      r_err   <= w_ferr;
      if (w_load) r_rx_d <= r_shift;
      if (r_state != DATA) r_idx <= '0;
      else if (w_sample)   r_idx <= r_idx + 3'd1;
      if (w_sample) r_shift[r_idx] <= r_rx_s;
    end
  end

  assign bus.rx_d     = r_rx_d;
  assign bus.rx_valid = r_valid;
  assign bus.rx_err   = r_err;
  assign bus.rx_busy  = (r_state != IDLE);
endmodule
